// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT input packer.
// Latency: n/a. Backpressure: n/a.
package fft_pkg;

    localparam int IN_WIDTH = 9;
    localparam int NUM      = 16;
    localparam int DATA     = 512;
    localparam int LANE_W   = $clog2(NUM);
    localparam int SLICE_W  = $clog2(DATA / NUM);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD
    } state_e;

endpackage

// File: rtl/fft_input_packer.sv
// Packs a serial I/Q stream into NUM-lane slices and zero-pads frames closed early by flush.
// Latency: slice registered on the edge that writes its last lane, visible for one cycle after it.
// Backpressure: ready_in drops only while padding; no downstream backpressure.
module fft_input_packer #(
    parameter int IN_WIDTH = fft_pkg::IN_WIDTH,
    parameter int NUM      = fft_pkg::NUM,
    parameter int DATA     = fft_pkg::DATA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_WIDTH-1:0] din_i,
    input  logic signed [IN_WIDTH-1:0] din_q,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       flush,
    output logic [NUM*IN_WIDTH-1:0]    dout_i,
    output logic [NUM*IN_WIDTH-1:0]    dout_q,
    output logic                       valid_out,
    output logic                       frame_start,
    output logic                       frame_end
);
    import fft_pkg::*;

    localparam int LANE_BITS  = $clog2(NUM);
    localparam int SLICES     = DATA / NUM;
    localparam int SLICE_BITS = $clog2(SLICES);
    localparam logic [LANE_BITS-1:0]  LAST_LANE  = LANE_BITS'(NUM - 1);
    localparam logic [SLICE_BITS-1:0] LAST_SLICE = SLICE_BITS'(SLICES - 1);

    state_e                    r_state;
    state_e                    w_next_state;
    logic [LANE_BITS-1:0]      r_lane_cnt;
    logic [SLICE_BITS-1:0]     r_slice_cnt;
    logic [NUM*IN_WIDTH-1:0]   r_pack_i;
    logic [NUM*IN_WIDTH-1:0]   r_pack_q;
    logic [NUM*IN_WIDTH-1:0]   w_slice_i;
    logic [NUM*IN_WIDTH-1:0]   w_slice_q;
    logic [IN_WIDTH-1:0]       w_smp_i;
    logic [IN_WIDTH-1:0]       w_smp_q;
    logic                      w_accept;
    logic                      w_write;
    logic                      w_last_lane;
    logic                      w_frame_done;

    assign ready_in     = (r_state != PAD) && !rst;
    assign w_accept     = valid_in && ready_in;
    // While padding, a zero is written every cycle exactly as if it were accepted.
    assign w_write      = w_accept || (r_state == PAD);
    assign w_smp_i      = (r_state == PAD) ? '0 : din_i;
    assign w_smp_q      = (r_state == PAD) ? '0 : din_q;
    assign w_last_lane  = (r_lane_cnt == LAST_LANE);
    assign w_frame_done = w_write && w_last_lane && (r_slice_cnt == LAST_SLICE);

    // Pack register with the current lane replaced, so the emitted slice includes this cycle's sample.
    always_comb begin
        w_slice_i = r_pack_i;
        w_slice_q = r_pack_q;
        w_slice_i[r_lane_cnt*IN_WIDTH +: IN_WIDTH] = w_smp_i;
        w_slice_q[r_lane_cnt*IN_WIDTH +: IN_WIDTH] = w_smp_q;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = FILL;
            FILL: begin
                if (w_frame_done)
                    w_next_state = IDLE;
                else if (flush)
                    w_next_state = PAD;
            end
            PAD:  if (w_frame_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane_cnt  <= '0;
            r_slice_cnt <= '0;
            r_pack_i    <= '0;
            r_pack_q    <= '0;
            dout_i      <= '0;
            dout_q      <= '0;
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (w_write) begin
                r_pack_i <= w_slice_i;
                r_pack_q <= w_slice_q;
                if (w_last_lane) begin
                    r_lane_cnt  <= '0;
                    dout_i      <= w_slice_i;
                    dout_q      <= w_slice_q;
                    valid_out   <= 1'b1;
                    frame_start <= (r_slice_cnt == '0);
                    frame_end   <= (r_slice_cnt == LAST_SLICE);
                    r_slice_cnt <= (r_slice_cnt == LAST_SLICE) ? '0 : r_slice_cnt + 1'b1;
                end else begin
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_input_packer.sv
// Randomized scoreboard bench for fft_input_packer against a frame-position reference model.
module tb_fft_input_packer;
    import fft_pkg::*;

    localparam int W  = IN_WIDTH;
    localparam int SW = NUM * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  din_i = '0;
    logic [W-1:0]  din_q = '0;
    logic          ready_in;
    logic [SW-1:0] dout_i;
    logic [SW-1:0] dout_q;
    logic          valid_out;
    logic          frame_start;
    logic          frame_end;

    always #5 clk = ~clk;

    fft_input_packer #(.IN_WIDTH(W), .NUM(NUM), .DATA(DATA)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_i       (din_i),
        .din_q       (din_q),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .flush       (flush),
        .dout_i      (dout_i),
        .dout_q      (dout_q),
        .valid_out   (valid_out),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    typedef struct {
        logic [SW-1:0] di;
        logic [SW-1:0] dq;
        bit            fs;
        bit            fe;
        int            edge_no;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    int            edge_n = 0;
    int            n_pulses = 0;
    int            m_p = 0;
    int            m_pad = 0;
    logic [SW-1:0] m_bi = '0;
    logic [SW-1:0] m_bq = '0;
    bit            prev_rst = 1'b0;
    bit            last_ready = 1'b0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Reference: a sample lands at frame position p; every NUM-th position closes a slice.
    task automatic model_write(input logic [W-1:0] si, input logic [W-1:0] sq);
        exp_t e;
        m_bi[(m_p % NUM)*W +: W] = si;
        m_bq[(m_p % NUM)*W +: W] = sq;
        m_p++;
        if (m_p % NUM == 0) begin
            e.di = m_bi;
            e.dq = m_bq;
            e.fs = (m_p == NUM);
            e.fe = (m_p == DATA);
            e.edge_no = edge_n;
            exp_q.push_back(e);
        end
        if (m_p == DATA) m_p = 0;
    endtask

    task automatic cycle(input bit r, input bit v, input bit f,
                         input logic [W-1:0] si, input logic [W-1:0] sq);
        bit was_idle;
        @(negedge clk);
        rst = r; valid_in = v; flush = f; din_i = si; din_q = sq;
        #1;
        if (prev_rst) begin
            chk("rst_dout_i", dout_i, '0);
            chk("rst_dout_q", dout_q, '0);
            chk("rst_flags", {valid_out, frame_start, frame_end}, '0);
        end
        chk("ready_in", ready_in, !r && (m_pad == 0));
        last_ready = ready_in;
        @(posedge clk);
        edge_n++;
        prev_rst = r;
        was_idle = (m_p == 0);
        if (r) begin
            m_p = 0;
            m_pad = 0;
        end else if (m_pad > 0) begin
            model_write('0, '0);
            m_pad--;
        end else begin
            if (v) model_write(si, sq);
            if (f && !was_idle && m_p != 0) m_pad = DATA - m_p;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_frame(input int n, input bit last_flush);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 1'b1, last_flush && (k == 0 || k == n - 1),
                  W'($urandom), W'($urandom));
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_out=1, expected no slice (edge %0d)", edge_n);
            end else begin
                mon_e = exp_q.pop_front();
                chk("slice_i", dout_i, mon_e.di);
                chk("slice_q", dout_q, mon_e.dq);
                chk("frame_start", frame_start, mon_e.fs);
                chk("frame_end", frame_end, mon_e.fe);
                chk("valid_timing", edge_n, mon_e.edge_no);
            end
        end else begin
            chk("flag_without_valid", {frame_start, frame_end}, 2'b00);
            if (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got no slice, expected one after edge %0d", mon_e.edge_no);
            end
        end
    end

    initial begin
        int base;
        int sent;
        int guard;
        int low;
        bit v;

        // Reset held with valid_in asserted.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom));

        // Continuous ramp frame.
        base = n_pulses;
        for (int i = 0; i < DATA; i++) cycle(1'b0, 1'b1, 1'b0, W'(i - 256), W'(255 - i));
        idle(2);
        chk("pulses_continuous", n_pulses - base, 32);

        // Gapped input.
        base = n_pulses;
        sent = 0;
        guard = 0;
        while (sent < DATA && guard < 4000) begin
            v = ($urandom_range(0, 2) != 0);
            cycle(1'b0, v, 1'b0, W'($urandom), W'($urandom));
            if (v) sent++;
            guard++;
        end
        chk("gapped_bound", guard < 4000, 1'b1);
        idle(2);
        chk("pulses_gapped", n_pulses - base, 32);

        // Flush mid-slice after 37 samples; valid/flush noise during padding.
        base = n_pulses;
        rand_frame(37, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        low = 0;
        for (int k = 0; k < DATA - 37; k++) begin
            cycle(1'b0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  W'($urandom), W'($urandom));
            if (!last_ready) low++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, '0);
            if (!last_ready) low++;
        end
        chk("pad_ready_low_cycles", low, DATA - 37);
        chk("pulses_flush", n_pulses - base, 32);

        // Flush in IDLE, then flush on first and final accepts of a frame.
        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        base = n_pulses;
        rand_frame(DATA, 1'b1);
        idle(3);
        chk("pulses_flush_last", n_pulses - base, 32);

        // Reset mid-frame, then a fresh frame.
        rand_frame(200, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom));
        cycle(1'b1, 1'b0, 1'b1, '0, '0);
        base = n_pulses;
        rand_frame(DATA, 1'b0);
        idle(3);
        chk("pulses_after_reset", n_pulses - base, 32);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
